// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_pkg
// Description : Shared opcode constants and immediate-format tags for the
//               decode-stage immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pipe_pkg;

  // Major opcodes, instruction bits [6:0]
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;

  // Immediate format tag reported on out_fmt
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_SH   = 3'd7
  } fmt_e;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational immediate extractor. Maps an instruction word
//               to its extended immediate, format tag and illegal flag.
// Revision    : 1.0 - initial release
// Ports       : ir      in   32    instruction word
//               imm     out  XLEN  extended immediate
//               fmt     out  3     format tag (fmt_e encoding)
//               illegal out  1     opcode not recognised
// ============================================================================
module imm_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  import imm_gen_pipe_pkg::*;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_shamt5;
  logic [XLEN-1:0] w_zimm;
  fmt_e            w_fmt;

  assign w_opcode = ir[6:0];
  assign w_funct3 = ir[14:12];

  // Size casts of signed operands sign-extend from ir[31] to XLEN.
  assign w_imm_i  = XLEN'($signed(ir[31:20]));
  assign w_imm_s  = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign w_imm_b  = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign w_imm_u  = XLEN'($signed({ir[31:12], 12'b0}));
  assign w_imm_j  = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
  // RV64 shifts use a 6-bit shamt; the *W forms and RV32 use 5 bits.
  assign w_shamt  = (XLEN == 64) ? XLEN'(ir[25:20]) : XLEN'(ir[24:20]);
  assign w_shamt5 = XLEN'(ir[24:20]);
  assign w_zimm   = XLEN'(ir[19:15]);

  always_comb begin
    imm     = '0;
    w_fmt   = FMT_NONE;
    illegal = 1'b0;
    case (w_opcode)
      OPC_OP_IMM: begin
        // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount
        if (w_funct3[1:0] == 2'b01) begin
          w_fmt = FMT_SH;
          imm   = w_shamt;
        end else begin
          w_fmt = FMT_I;
          imm   = w_imm_i;
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          if (w_funct3[1:0] == 2'b01) begin
            w_fmt = FMT_SH;
            imm   = w_shamt5;
          end else begin
            w_fmt = FMT_I;
            imm   = w_imm_i;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        w_fmt = FMT_I;
        imm   = w_imm_i;
      end
      OPC_STORE: begin
        w_fmt = FMT_S;
        imm   = w_imm_s;
      end
      OPC_BRANCH: begin
        w_fmt = FMT_B;
        imm   = w_imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_fmt = FMT_U;
        imm   = w_imm_u;
      end
      OPC_JAL: begin
        w_fmt = FMT_J;
        imm   = w_imm_j;
      end
      OPC_SYSTEM: begin
        // CSR immediate forms have funct3[2] set
        if (w_funct3[2]) begin
          w_fmt = FMT_Z;
          imm   = w_zimm;
        end
      end
      OPC_OP, OPC_FENCE: begin
        w_fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign fmt = w_fmt;

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered valid/ready immediate generator for the decode
//               stage, with optional 2-entry skid buffer. Emits immediate,
//               format tag, illegal flag, pc and pc+imm one cycle after accept.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n (async active-low), flush (sync kill)
//               in_valid/in_ready/in_ir/in_pc       upstream handshake
//               out_valid/out_ready                 downstream handshake
//               out_imm/out_fmt/out_illegal/out_target/out_pc  result
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);

  // Entry layout: {pc, target, imm, fmt, illegal}
  localparam int EW = 3 * XLEN + 4;

  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_illegal;
  logic [EW-1:0]   w_in_entry;
  logic            w_accept;
  logic            w_consume;
  logic            w_m_free;
  logic            w_m_next_valid;
  logic [EW-1:0]   w_m_next_entry;
  logic            r_m_valid;
  logic [EW-1:0]   r_m_entry;

  imm_decode #(
    .XLEN    (XLEN)
  ) u_imm_decode (
    .ir      (in_ir),
    .imm     (w_dec_imm),
    .fmt     (w_dec_fmt),
    .illegal (w_dec_illegal)
  );

  // Target adder sits before the register so the output is a clean flop.
  assign w_in_entry = {in_pc, in_pc + w_dec_imm, w_dec_imm, w_dec_fmt, w_dec_illegal};

  // flush discards any same-cycle input.
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_consume = r_m_valid && out_ready;
  assign w_m_free  = !r_m_valid || w_consume;

  generate
    if (SKID != 0) begin : g_skid
      logic          r_k_valid;
      logic [EW-1:0] r_k_entry;

      // in_ready comes straight off a flop: only a full skid stalls input.
      assign in_ready = !r_k_valid;

      // K is only ever occupied while M is full; when M frees up K always
      // moves across, and no input is accepted that cycle (in_ready was 0).
      assign w_m_next_valid = r_k_valid || w_accept;
      assign w_m_next_entry = r_k_valid ? r_k_entry : w_in_entry;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_k_valid <= 1'b0;
          r_k_entry <= '0;
        end else if (flush) begin
          r_k_valid <= 1'b0;
        end else if (w_m_free) begin
          r_k_valid <= 1'b0;
        end else if (w_accept) begin
          r_k_valid <= 1'b1;
          r_k_entry <= w_in_entry;
        end
      end
    end else begin : g_noskid
      assign in_ready       = !r_m_valid || out_ready;
      assign w_m_next_valid = w_accept;
      assign w_m_next_entry = w_in_entry;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_entry <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
    end else if (w_m_free) begin
      r_m_valid <= w_m_next_valid;
      // Data only moves on a real load, so it stays stable under stall.
      if (w_m_next_valid) begin
        r_m_entry <= w_m_next_entry;
      end
    end
  end

  assign out_valid = r_m_valid;
  assign {out_pc, out_target, out_imm, out_fmt, out_illegal} = r_m_entry;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe. Three instances
//               (XLEN32/SKID1, XLEN32/SKID0, XLEN64/SKID1) share one random
//               stimulus stream; each has its own scoreboard fed by an
//               arithmetic reference decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] target;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] ir = '0;
  logic [63:0] pc = '0;
  logic        out_ready = 1'b0;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [31:0] imm0, tgt0, opc0, imm1, tgt1, opc1;
  logic [63:0] imm2, tgt2, opc2;
  logic [2:0]  fmt0, fmt1, fmt2;
  logic        ill0, ill1, ill2;

  int n_checks = 0;
  int n_pass   = 0;
  ent_t sb [3][$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_ir(ir), .in_pc(pc[31:0]), .out_valid(vld0), .out_ready(out_ready),
    .out_imm(imm0), .out_fmt(fmt0), .out_illegal(ill0), .out_target(tgt0), .out_pc(opc0));

  imm_gen_pipe #(.XLEN(32), .SKID(0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_ir(ir), .in_pc(pc[31:0]), .out_valid(vld1), .out_ready(out_ready),
    .out_imm(imm1), .out_fmt(fmt1), .out_illegal(ill1), .out_target(tgt1), .out_pc(opc1));

  imm_gen_pipe #(.XLEN(64), .SKID(1)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_ir(ir), .in_pc(pc), .out_valid(vld2), .out_ready(out_ready),
    .out_imm(imm2), .out_fmt(fmt2), .out_illegal(ill2), .out_target(tgt2), .out_pc(opc2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference decoder: immediates assembled arithmetically from field values.
  function automatic ent_t ref_model(input logic [31:0] w, input logic [63:0] p, input int xlen);
    ent_t   r;
    longint sx, u, hi, t, imm;
    int     op, f3, fmt;
    bit     ill;
    sx  = longint'($signed(w));
    u   = longint'({32'b0, w});
    hi  = sx >>> 31;           // 0 or -1: the sign
    op  = int'(u & 127);
    f3  = int'((u >> 12) & 7);
    imm = 0; fmt = 0; ill = 1'b0;
    case (op)
      'h13: if (f3 == 1 || f3 == 5) begin fmt = 7; imm = (u >> 20) & ((xlen == 64) ? 63 : 31); end
            else begin fmt = 1; imm = sx >>> 20; end
      'h1B: if (xlen != 64) ill = 1'b1;
            else if (f3 == 1 || f3 == 5) begin fmt = 7; imm = (u >> 20) & 31; end
            else begin fmt = 1; imm = sx >>> 20; end
      'h03, 'h67: begin fmt = 1; imm = sx >>> 20; end
      'h23: begin fmt = 2; t = sx >>> 25; imm = t * 32 + ((u >> 7) & 31); end
      'h63: begin fmt = 3;
              imm = hi * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
            end
      'h37, 'h17: begin fmt = 4; t = sx >>> 12; imm = t * 4096; end
      'h6F: begin fmt = 5;
              imm = hi * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
            end
      'h73: if (f3 >= 4) begin fmt = 6; imm = (u >> 15) & 31; end
      'h33, 'h0F: fmt = 0;
      default: ill = 1'b1;
    endcase
    r.imm    = imm;
    r.pc     = p;
    r.target = p + imm;
    r.fmt    = 3'(fmt);
    r.ill    = ill;
    if (xlen == 32) begin
      r.imm[63:32]    = '0;
      r.pc[63:32]     = '0;
      r.target[63:32] = '0;
    end
    return r;
  endfunction

  task automatic mon(input int id, input logic v, input logic rdy, input logic [63:0] imm,
                     input logic [63:0] tgt, input logic [63:0] opc, input logic [2:0] fmt,
                     input logic ill);
    ent_t e;
    bit   skid = (id != 1);
    int   xl   = (id == 2) ? 64 : 32;
    chk($sformatf("u%0d out_valid", id), 64'(v), 64'(sb[id].size() > 0));
    if (skid) chk($sformatf("u%0d in_ready", id), 64'(rdy), 64'(sb[id].size() < 2));
    else      chk($sformatf("u%0d in_ready", id), 64'(rdy), 64'(sb[id].size() == 0 || out_ready));
    if (v && sb[id].size() > 0) begin
      e = sb[id][0];
      chk($sformatf("u%0d out_imm", id),     imm, e.imm);
      chk($sformatf("u%0d out_fmt", id),     64'(fmt), 64'(e.fmt));
      chk($sformatf("u%0d out_illegal", id), 64'(ill), 64'(e.ill));
      chk($sformatf("u%0d out_target", id),  tgt, e.target);
      chk($sformatf("u%0d out_pc", id),      opc, e.pc);
      if (out_ready) void'(sb[id].pop_front());
    end
    if (in_valid && rdy && !flush) sb[id].push_back(ref_model(ir, pc, xl));
    if (flush) sb[id].delete();
  endtask

  // Single compare process, mid-cycle: inputs and outputs are both settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) sb[i].delete();
    end else begin
      mon(0, vld0, rdy0, {32'b0, imm0}, {32'b0, tgt0}, {32'b0, opc0}, fmt0, ill0);
      mon(1, vld1, rdy1, {32'b0, imm1}, {32'b0, tgt1}, {32'b0, opc1}, fmt1, ill1);
      mon(2, vld2, rdy2, imm2, tgt2, opc2, fmt2, ill2);
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] p,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #2;
    in_valid  = v;
    ir        = w;
    pc        = p;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One instruction, then one idle cycle; output is checked mid idle cycle.
  task automatic one_shot(input logic [31:0] w, input logic [63:0] p);
    drive(1'b1, w, p, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                           7'h6F, 7'h73, 7'h33, 7'h0F, 7'h1B, 7'h7F};

  initial begin
    ent_t        m;
    logic [31:0] r;
    int          k;

    // Pin the reference model with hand-derived values
    m = ref_model(32'hFFF00093, 64'h0, 32);
    chk("model addi imm", m.imm, 64'hFFFFFFFF);
    chk("model addi target", m.target, 64'hFFFFFFFF);
    m = ref_model(32'hFE000EE3, 64'h100, 32);
    chk("model beq imm", m.imm, 64'hFFFFFFFC);
    chk("model beq target", m.target, 64'hFC);
    m = ref_model(32'h800000B7, 64'h0, 64);
    chk("model lui imm", m.imm, 64'hFFFFFFFF80000000);
    m = ref_model(32'h4210D093, 64'h0, 64);
    chk("model srai imm", m.imm, 64'd33);
    m = ref_model(32'h300FD073, 64'h0, 64);
    chk("model csrrwi fmt", 64'(m.fmt), 64'd6);
    m = ref_model(32'h0000007F, 64'h0, 64);
    chk("model illegal", 64'(m.ill), 64'd1);

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset out_valid", 64'(vld0), 64'd0);
    chk("reset out_imm", 64'(imm0), 64'd0);
    chk("reset out_fmt", 64'(fmt0), 64'd0);
    chk("reset out_illegal", 64'(ill0), 64'd0);
    chk("reset out_target", 64'(tgt0), 64'd0);
    chk("reset out_pc", 64'(opc0), 64'd0);
    chk("reset in_ready", 64'(rdy0), 64'd1);
    chk("reset in_ready noskid", 64'(rdy1), 64'd1);

    // Directed decodes
    one_shot(32'hFFF00093, 64'h0);
    chk("addi valid", 64'(vld0), 64'd1);
    chk("addi imm", 64'(imm0), 64'hFFFFFFFF);
    chk("addi fmt", 64'(fmt0), 64'd1);
    chk("addi target", 64'(tgt0), 64'hFFFFFFFF);
    chk("addi illegal", 64'(ill0), 64'd0);
    one_shot(32'hFE000EE3, 64'h100);
    chk("beq imm", 64'(imm0), 64'hFFFFFFFC);
    chk("beq fmt", 64'(fmt0), 64'd3);
    chk("beq target", 64'(tgt0), 64'hFC);
    one_shot(32'h800000B7, 64'h0);
    chk("lui64 imm", imm2, 64'hFFFFFFFF80000000);
    chk("lui64 fmt", 64'(fmt2), 64'd4);
    one_shot(32'h4210D093, 64'h0);
    chk("srai64 imm", imm2, 64'd33);
    chk("srai64 fmt", 64'(fmt2), 64'd7);
    one_shot(32'h300FD073, 64'h0);
    chk("csrrwi64 imm", imm2, 64'd31);
    chk("csrrwi64 fmt", 64'(fmt2), 64'd6);
    one_shot(32'h0000007F, 64'h0);
    chk("illegal64 flag", 64'(ill2), 64'd1);
    chk("illegal64 imm", imm2, 64'd0);

    // Skid fill under stall, then drain in order
    drive(1'b1, 32'h00100093, 64'h10, 1'b0, 1'b0);
    drive(1'b1, 32'h00200093, 64'h14, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 64'h18, 1'b0, 1'b0);
    @(negedge clk);
    chk("skid full in_ready", 64'(rdy0), 64'd0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h00300093, 64'h18, 1'b1, 1'b0);
    repeat (4) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Flush with M and K full and input offered
    drive(1'b1, 32'h00400093, 64'h20, 1'b0, 1'b0);
    drive(1'b1, 32'h00500093, 64'h24, 1'b0, 1'b0);
    drive(1'b1, 32'h00600093, 64'h28, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush out_valid", 64'(vld0), 64'd0);
    chk("flush in_ready", 64'(rdy0), 64'd1);
    chk("flush out_valid noskid", 64'(vld1), 64'd0);

    // Asynchronous reset mid-operation
    drive(1'b1, 32'h00700093, 64'h30, 1'b0, 1'b0);
    drive(1'b1, 32'h00800093, 64'h34, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(vld0), 64'd0);
    chk("async reset out_imm", 64'(imm0), 64'd0);
    chk("async reset out_pc64", opc2, 64'd0);
    chk("async reset in_ready", 64'(rdy0), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 12000; n++) begin
      r = $urandom;
      k = $urandom_range(0, 13);
      if (k < 13) ir = {r[31:7], ops[k]};
      drive($urandom_range(0, 99) < 70, (k < 13) ? {r[31:7], ops[k]} : r,
            {$urandom, $urandom}, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 2);
    end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d drained", i), 64'(sb[i].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
